imem_loader: RTL and testbench

Program loader that writes instruction memory: the write-side counterpart of the CPU's read-only, word-indexed instruction store. It accepts a byte stream from a host or UART front-end over a valid/ready handshake. It assembles little-endian 32-bit words and issues one-cycle word writes at consecutive word indices starting at 0. While a load is in progress it holds the CPU in reset, and releases it when the programmed word count has been written.

---
 rtl/imem_loader.sv | 144 ++++++++++++++
 tb/tb_imem_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writes a program into the word-indexed instruction memory from a byte
//   stream. Bytes arrive least-significant first over a valid/ready handshake,
//   are packed into 32-bit words and written one word per WRITE cycle at
//   consecutive word indices starting at 0. The CPU is held in reset until the
//   requested number of words has been written.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   start, load_words     begin a load of load_words words (1..DEPTH)
//   byte_valid, byte_data byte stream in (LSB of each word first)
//   byte_ready            loader accepts a byte this cycle
//   mem_we/addr/wdata     one-cycle word write to instruction memory
//   cpu_hold              CPU reset hold; low only once the load is complete
//   busy, done, error     status: loading, complete, sticky illegal length
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] load_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      shift_q,    shift_d;
  logic [31:0]      addr_q,     addr_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic             error_q,    error_d;
  logic             len_legal;

  // Compare at LEN_W bits so load_words == DEPTH is accepted.
  assign len_legal = (load_words != '0) && (load_words <= LEN_W'(DEPTH));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (len_legal) begin
            len_d      = load_words;
            word_idx_d = '0;
            byte_idx_d = '0;
            shift_d    = '0;
            error_d    = 1'b0;
            state_d    = S_RECV;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_RECV: begin
        if (byte_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: shift_d[7:0]   = byte_data;
            2'd1: shift_d[15:8]  = byte_data;
            2'd2: shift_d[23:16] = byte_data;
            default: begin
              // Fourth byte completes the word; capture the write operands so
              // they stay stable through WRITE and are held afterwards.
              addr_d  = 32'(word_idx_q);
              wdata_d = {byte_data, shift_q};
              state_d = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        if (word_idx_q == len_q - LEN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + LEN_W'(1);
          state_d    = S_RECV;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
    end
  end

  assign byte_ready = (state_q == S_RECV);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  load_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(16), .LEN_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .load_words(load_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_we_cyc = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mem_model [0:15];

  // status = {byte_ready, mem_we, busy, done, cpu_hold, error}
  localparam logic [5:0] ST_IDLE     = 6'b000010;
  localparam logic [5:0] ST_IDLE_ERR = 6'b000011;
  localparam logic [5:0] ST_RECV     = 6'b101010;
  localparam logic [5:0] ST_DONE     = 6'b000100;
  localparam logic [5:0] ST_DONE_ERR = 6'b000101;

  // Advance one clock, sample after the edge, and consume any memory write
  // against the scoreboard.
  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      last_we_cyc = cyc;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e)
          $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        else pass_cnt++;
      end
      chk_cnt++;
      if (byte_ready !== 1'b0) $display("FAIL ready_in_write: got %b want 0", byte_ready);
      else pass_cnt++;
      if (mem_addr < 32'd16) mem_model[mem_addr[3:0]] = mem_wdata;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    bit ok;
    if (stall) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    do begin
      ok = byte_ready;
      step();
      guard++;
    end while (!ok && guard < 50);
    if (!ok) begin
      chk_cnt++;
      $display("FAIL byte_timeout: byte %h not accepted in %0d cycles, want accepted", b, guard);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], stall);
  endtask

  task automatic do_start(input logic [4:0] n);
    start = 1'b1;
    load_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; load_words = '0; byte_valid = 1'b0; byte_data = '0;
    step(); step();
    rst = 1'b0;
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_IDLE)
      $display("FAIL reset_status: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_IDLE);
    else pass_cnt++;
    chk_cnt++;
    if ({mem_addr, mem_wdata} !== 64'd0)
      $display("FAIL reset_mem_bus: got addr=%h data=%h want 0/0", mem_addr, mem_wdata);
    else pass_cnt++;
  endtask

  task automatic test_single_word();
    int w0;
    w0 = wr_cnt;
    exp_q.push_back({32'd0, 32'h00100013});
    do_start(5'd1);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_RECV)
      $display("FAIL single_recv: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_RECV);
    else pass_cnt++;
    send_word(32'h00100013, 1'b0);
    chk_cnt++;
    if (mem_we !== 1'b1) $display("FAIL single_we: got %b want 1", mem_we);
    else pass_cnt++;
    byte_valid = 1'b0;
    step();
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_DONE)
      $display("FAIL single_done: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_DONE);
    else pass_cnt++;
    byte_valid = 1'b1;
    repeat (3) step();
    byte_valid = 1'b0;
    chk_cnt++;
    if ({byte_ready, done, cpu_hold} !== 3'b010 || (wr_cnt - w0) !== 1)
      $display("FAIL single_after: got ready/done/hold=%b writes=%0d want 010 writes=1",
               {byte_ready, done, cpu_hold}, wr_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    int w0;
    rst = 1'b1; step(); rst = 1'b0;
    w0 = wr_cnt;
    do_start(5'd0);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_IDLE_ERR)
      $display("FAIL len0: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_IDLE_ERR);
    else pass_cnt++;
    byte_valid = 1'b1;
    repeat (3) step();
    byte_valid = 1'b0;
    do_start(5'd17);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_IDLE_ERR || wr_cnt != w0)
      $display("FAIL len17: got %b writes=%0d want %b writes=0",
               {byte_ready, mem_we, busy, done, cpu_hold, error}, wr_cnt - w0, ST_IDLE_ERR);
    else pass_cnt++;
    do_start(5'd2);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_RECV)
      $display("FAIL legal_after_err: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_RECV);
    else pass_cnt++;
    exp_q.push_back({32'd0, 32'h11223344});
    exp_q.push_back({32'd1, 32'h55667788});
    send_word(32'h11223344, 1'b1);
    send_word(32'h55667788, 1'b1);
    byte_valid = 1'b0;
    step();
    do_start(5'd0);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_DONE_ERR)
      $display("FAIL len0_in_done: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_DONE_ERR);
    else pass_cnt++;
  endtask

  task automatic test_full_load();
    int w0;
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) exp_q.push_back({32'(i), 32'hA0000000 + 32'(i)});
    do_start(5'd16);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_RECV)
      $display("FAIL full_start: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_RECV);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) send_word(32'hA0000000 + 32'(i), 1'b1);
    byte_valid = 1'b0;
    step();
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_DONE || (wr_cnt - w0) !== 16)
      $display("FAIL full_done: got %b writes=%0d want %b writes=16",
               {byte_ready, mem_we, busy, done, cpu_hold, error}, wr_cnt - w0, ST_DONE);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      chk_cnt++;
      if (mem_model[i] !== 32'hA0000000 + 32'(i))
        $display("FAIL full_mem[%0d]: got %h want %h", i, mem_model[i], 32'hA0000000 + 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_start(5'd3);
    exp_q.push_back({32'd0, 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    w0 = wr_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_IDLE)
      $display("FAIL rst_mid: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_IDLE);
    else pass_cnt++;
    byte_data = 8'h03;
    repeat (6) step();
    byte_valid = 1'b0;
    chk_cnt++;
    if (wr_cnt != w0 || busy !== 1'b0)
      $display("FAIL rst_mid_quiet: got writes=%0d busy=%b want writes=0 busy=0", wr_cnt - w0, busy);
    else pass_cnt++;
    chk_cnt++;
    if (mem_model[0] !== 32'hCAFEF00D) $display("FAIL rst_mid_mem0: got %h want cafef00d", mem_model[0]);
    else pass_cnt++;
  endtask

  task automatic test_reload();
    do_start(5'd2);
    exp_q.push_back({32'd0, 32'h01020304});
    exp_q.push_back({32'd1, 32'h05060708});
    send_word(32'h01020304, 1'b1);
    send_word(32'h05060708, 1'b1);
    byte_valid = 1'b0;
    step();
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_DONE)
      $display("FAIL reload_done1: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_DONE);
    else pass_cnt++;
    do_start(5'd1);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_RECV)
      $display("FAIL reload_start: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_RECV);
    else pass_cnt++;
    exp_q.push_back({32'd0, 32'h0BADBEEF});
    send_byte(8'hEF, 1'b0);
    byte_valid = 1'b0;
    do_start(5'd5);
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_RECV)
      $display("FAIL start_in_recv: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_RECV);
    else pass_cnt++;
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'h0B, 1'b0);
    byte_valid = 1'b0;
    step();
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_DONE)
      $display("FAIL reload_done2: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_DONE);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int prev;
    do_start(5'd3);
    for (int k = 0; k < 3; k++) begin
      b = 8'h40 + 8'(4 * k);
      exp_q.push_back({32'(k), b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    prev = 0;
    for (int k = 0; k < 12; k++) begin
      send_byte(8'h40 + 8'(k), 1'b0);
      if (k % 4 == 3) begin
        chk_cnt++;
        if (mem_we !== 1'b1) $display("FAIL b2b_we[%0d]: got %b want 1", k / 4, mem_we);
        else pass_cnt++;
        if (k > 3) begin
          chk_cnt++;
          if (last_we_cyc - prev !== 5)
            $display("FAIL b2b_spacing[%0d]: got %0d cycles want 5", k / 4, last_we_cyc - prev);
          else pass_cnt++;
        end
        prev = last_we_cyc;
      end
    end
    byte_valid = 1'b0;
    step();
    chk_cnt++;
    if ({byte_ready, mem_we, busy, done, cpu_hold, error} !== ST_DONE)
      $display("FAIL b2b_done: got %b want %b", {byte_ready, mem_we, busy, done, cpu_hold, error}, ST_DONE);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    test_reset();
    test_single_word();
    test_illegal();
    test_full_load();
    test_reset_mid();
    test_reload();
    test_back_to_back();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending writes want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
